// File: rtl/axi4l_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4l_pkg
//  Description : Shared AXI4-Lite response codes and RAM controller FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi4l_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        B_RESP = 2'd1,
        R_WAIT = 2'd2,
        R_RESP = 2'd3
    } ram_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/axi4l_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi4l_ram_ctrl_if
//  Description : AXI4-Lite bus bundle between an initiator and the RAM controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi4l_ram_ctrl_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface
`default_nettype wire

// File: rtl/axi4l_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : axi4l_ram_ctrl
//  Description : AXI4-Lite responder driving a 32-bit block RAM, one transaction
//                outstanding, read/write arbitration by alternating priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4l_ram_ctrl
    import axi4l_pkg::*;
#(
    parameter  int SIZE       = 'h80,
    localparam int ADDR_WIDTH = $clog2(SIZE) - 2
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    axi4l_ram_ctrl_if.slave            s_axi,
    output logic [ADDR_WIDTH-1:0]      ram_waddr,
    output logic [ADDR_WIDTH-1:0]      ram_raddr,
    output logic                       ram_ce,
    output logic [3:0]                 ram_we,
    output logic [31:0]                ram_d,
    input  wire logic [31:0]           ram_q
);

    ram_ctrl_state_t        state_q, state_d;
    logic                   last_was_write_q, last_was_write_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0]  raddr_q, raddr_d;
    logic [31:0]            wdata_q, wdata_d;

    logic want_w;
    logic want_r;
    logic grant_w;
    logic grant_r;
    logic unused_addr_bits;

    // Byte-offset and out-of-range address bits are dropped so accesses alias modulo SIZE.
    assign unused_addr_bits = ^{s_axi.awaddr[31:ADDR_WIDTH+2], s_axi.awaddr[1:0],
                                s_axi.araddr[31:ADDR_WIDTH+2], s_axi.araddr[1:0]};

    always_comb begin
        state_d          = state_q;
        last_was_write_d = last_was_write_q;
        rdata_d          = rdata_q;
        waddr_d          = waddr_q;
        raddr_d          = raddr_q;
        wdata_d          = wdata_q;
        want_w           = 1'b0;
        want_r           = 1'b0;
        grant_w          = 1'b0;
        grant_r          = 1'b0;
        ram_ce           = 1'b0;
        ram_we           = 4'b0000;
        s_axi.bvalid     = 1'b0;
        s_axi.rvalid     = 1'b0;

        case (state_q)
            IDLE: begin
                want_w  = s_axi.awvalid & s_axi.wvalid;
                want_r  = s_axi.arvalid;
                // Under contention the kind not served last time wins.
                grant_w = want_w & (~want_r | ~last_was_write_q);
                grant_r = want_r & (~want_w |  last_was_write_q);
                if (grant_w) begin
                    ram_ce           = 1'b1;
                    ram_we           = s_axi.wstrb;
                    waddr_d          = s_axi.awaddr[ADDR_WIDTH+1:2];
                    wdata_d          = s_axi.wdata;
                    last_was_write_d = 1'b1;
                    state_d          = B_RESP;
                end else if (grant_r) begin
                    ram_ce           = 1'b1;
                    raddr_d          = s_axi.araddr[ADDR_WIDTH+1:2];
                    last_was_write_d = 1'b0;
                    state_d          = R_WAIT;
                end
            end
            B_RESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) state_d = IDLE;
            end
            R_WAIT: begin
                rdata_d = ram_q;
                state_d = R_RESP;
            end
            R_RESP: begin
                s_axi.rvalid = 1'b1;
                if (s_axi.rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant cycles present the live request; other cycles replay the last values.
    assign ram_waddr     = waddr_d;
    assign ram_raddr     = raddr_d;
    assign ram_d         = wdata_d;

    assign s_axi.awready = grant_w;
    assign s_axi.wready  = grant_w;
    assign s_axi.arready = grant_r;
    assign s_axi.bresp   = OKAY;
    assign s_axi.rresp   = OKAY;
    assign s_axi.rdata   = rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            last_was_write_q <= 1'b1;
            rdata_q          <= 32'h0;
            waddr_q          <= '0;
            raddr_q          <= '0;
            wdata_q          <= 32'h0;
        end else begin
            state_q          <= state_d;
            last_was_write_q <= last_was_write_d;
            rdata_q          <= rdata_d;
            waddr_q          <= waddr_d;
            raddr_q          <= raddr_d;
            wdata_q          <= wdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4l_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4l_ram_ctrl
//  Description : Self-checking bench for axi4l_ram_ctrl with a behavioural RAM
//                and a word-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4l_ram_ctrl;
    import axi4l_pkg::*;

    localparam int SIZE = 'h80;
    localparam int AW   = $clog2(SIZE) - 2;
    localparam int NW   = SIZE / 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic          ram_ce;
    logic [3:0]    ram_we;
    logic [31:0]   ram_d;
    logic [31:0]   ram_q;

    axi4l_ram_ctrl_if bus();

    axi4l_ram_ctrl #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_axi     (bus.slave),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_d     (ram_d),
        .ram_q     (ram_q)
    );

    always #5 clk = ~clk;

    // Behavioural block RAM with an override so the bench can disturb ram_q.
    logic [31:0] mem [0:NW-1];
    logic [31:0] mem_q;
    logic        clr_mem;
    logic        ovr;
    logic [31:0] ovr_val;
    assign ram_q = ovr ? ovr_val : mem_q;

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < NW; i++) mem[i] <= 32'h0;
            mem_q <= 32'h0;
        end else if (ram_ce) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_waddr][8*b +: 8] <= ram_d[8*b +: 8];
            mem_q <= mem[ram_raddr];
        end
    end

    // Reference model: word array plus the arbiter priority flag.
    logic [31:0] ref_mem [0:NW-1];
    logic        ref_last_write;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic int widx(input logic [31:0] a);
        return int'((a % SIZE) / 4);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = ref_mem[widx(a)];
        for (int b = 0; b < 4; b++)
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[widx(a)] = w;
    endtask

    task automatic idle_inputs();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        bus.bready  = 1'b1; bus.rready = 1'b1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int cyc = 0;
        @(negedge clk);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        #1;
        while (!bus.awready && cyc < 20) begin @(negedge clk); #1; cyc++; end
        n_checks++;
        if (!(bus.awready && bus.wready && ram_we === s)) begin
            n_fail++;
            $display("FAIL wr_grant addr=%h awready=%b wready=%b ram_we=%h expected 1 1 %h", a, bus.awready, bus.wready, ram_we, s);
        end
        ref_write(a, d, s); ref_last_write = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        #1;
        n_checks++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
            n_fail++;
            $display("FAIL wr_bresp bvalid=%b bresp=%b expected 1 00", bus.bvalid, bus.bresp);
        end
        @(negedge clk); #1;
        n_checks++;
        if (bus.bvalid !== 1'b0) begin
            n_fail++; $display("FAIL wr_bdone bvalid=%b expected 0", bus.bvalid);
        end
    endtask

    task automatic do_read(input logic [31:0] a);
        int cyc = 0;
        logic [31:0] exp;
        @(negedge clk);
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
        #1;
        while (!bus.arready && cyc < 20) begin @(negedge clk); #1; cyc++; end
        n_checks++;
        if (bus.arready !== 1'b1) begin
            n_fail++; $display("FAIL rd_grant addr=%h arready=%b expected 1", a, bus.arready);
        end
        exp = ref_mem[widx(a)]; ref_last_write = 1'b0;
        @(negedge clk);
        bus.arvalid = 1'b0;
        #1;
        n_checks++;
        if (bus.rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rd_wait rvalid=%b expected 0", bus.rvalid);
        end
        @(negedge clk); #1;
        n_checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== exp || bus.rresp !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_data addr=%h rvalid=%b rdata=%h rresp=%b expected 1 %h 00", a, bus.rvalid, bus.rdata, bus.rresp, exp);
        end
        @(negedge clk); #1;
        n_checks++;
        if (bus.rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rd_done rvalid=%b expected 0", bus.rvalid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clr_mem = 1'b1; ovr = 1'b0; ovr_val = 32'h0;
        bus.awaddr = 32'h0; bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.araddr = 32'h0;
        idle_inputs();
        for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
        ref_last_write = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0 || bus.awready !== 1'b0 || bus.arready !== 1'b0 ||
            ram_ce !== 1'b0 || ram_we !== 4'h0 || bus.rdata !== 32'h0 || bus.bresp !== 2'b00 ||
            bus.rresp !== 2'b00 || dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state bv=%b rv=%b awr=%b arr=%b ce=%b we=%h rdata=%h st=%0d expected all zero/IDLE",
                     bus.bvalid, bus.rvalid, bus.awready, bus.arready, ram_ce, ram_we, bus.rdata, dut.state_q);
        end
        @(negedge clk);
        reset = 1'b0; clr_mem = 1'b0;
    endtask

    task automatic test_basic();
        do_write(32'h04, 32'hDEADBEEF, 4'hF);
        do_read(32'h04);
    endtask

    task automatic test_strobes();
        do_write(32'h08, 32'h11223344, 4'hF);
        do_write(32'h08, 32'hAABBCCDD, 4'h5);
        n_checks++;
        if (ref_mem[2] !== 32'h11BB33DD) begin
            n_fail++; $display("FAIL strobe_model got=%h expected 11bb33dd", ref_mem[2]);
        end
        do_read(32'h08);
    endtask

    task automatic contend(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
        string       order = "";
        string       exp_order;
        logic        got_b = 1'b0, got_r = 1'b0, clr_r = 1'b0, clr_w = 1'b0;
        logic [31:0] exp_r = 32'h0;
        exp_order = ref_last_write ? "RW" : "WR";
        @(negedge clk);
        bus.awaddr = wa; bus.wdata = wd; bus.wstrb = 4'hF; bus.araddr = ra;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        for (int c = 0; c < 30 && !(got_b && got_r); c++) begin
            if (c > 0) @(negedge clk);
            if (clr_r) bus.arvalid = 1'b0;
            if (clr_w) begin bus.awvalid = 1'b0; bus.wvalid = 1'b0; end
            clr_r = 1'b0; clr_w = 1'b0;
            #1;
            if (bus.arready && bus.awready) begin
                n_checks++; n_fail++; $display("FAIL contend_both arready=1 awready=1 expected one grant");
            end
            if (bus.arready) begin
                order = {order, "R"}; exp_r = ref_mem[widx(ra)]; clr_r = 1'b1; ref_last_write = 1'b0;
            end else if (bus.awready) begin
                order = {order, "W"}; ref_write(wa, wd, 4'hF); clr_w = 1'b1; ref_last_write = 1'b1;
            end
            if (bus.rvalid) begin
                got_r = 1'b1;
                n_checks++;
                if (bus.rdata !== exp_r) begin
                    n_fail++; $display("FAIL contend_rdata got=%h expected %h", bus.rdata, exp_r);
                end
            end
            if (bus.bvalid) got_b = 1'b1;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        n_checks++;
        if (order != exp_order || !got_b || !got_r) begin
            n_fail++;
            $display("FAIL contend_order got=%s b=%b r=%b expected %s 1 1", order, got_b, got_r, exp_order);
        end
    endtask

    task automatic test_contention();
        contend(32'h00, $urandom, 32'h10);
        do_read(32'h00);
        contend(32'h00, $urandom, 32'h10);
        contend(32'h10, $urandom, 32'h00);
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        do_write(32'h0C, $urandom, 4'hF);
        exp = ref_mem[3];
        @(negedge clk);
        bus.araddr = 32'h0C; bus.arvalid = 1'b1; bus.rready = 1'b0;
        #1;
        n_checks++;
        if (bus.arready !== 1'b1) begin n_fail++; $display("FAIL bp_rgrant arready=%b expected 1", bus.arready); end
        ref_last_write = 1'b0;
        @(negedge clk); bus.arvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ovr = 1'b1; ovr_val = $urandom;
            bus.awaddr = 32'h18; bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
            #1;
            n_checks++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== exp || bus.arready !== 1'b0 || bus.awready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_rhold rvalid=%b rdata=%h arr=%b awr=%b expected 1 %h 0 0", bus.rvalid, bus.rdata, bus.arready, bus.awready, exp);
            end
        end
        @(negedge clk);
        ovr = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0; bus.rready = 1'b1;
        #1;
        n_checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== exp) begin
            n_fail++; $display("FAIL bp_rrel rvalid=%b rdata=%h expected 1 %h", bus.rvalid, bus.rdata, exp);
        end
        @(negedge clk); #1;
        n_checks++;
        if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL bp_rdone rvalid=%b expected 0", bus.rvalid); end

        // Write response held under bready backpressure.
        @(negedge clk);
        bus.awaddr = 32'h1C; bus.wdata = $urandom; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        #1;
        n_checks++;
        if (bus.awready !== 1'b1) begin n_fail++; $display("FAIL bp_wgrant awready=%b expected 1", bus.awready); end
        ref_write(32'h1C, bus.wdata, 4'hF); ref_last_write = 1'b1;
        @(negedge clk); bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.arvalid = 1'b1; bus.araddr = 32'h1C;
            #1;
            n_checks++;
            if (bus.bvalid !== 1'b1 || bus.arready !== 1'b0) begin
                n_fail++; $display("FAIL bp_bhold bvalid=%b arready=%b expected 1 0", bus.bvalid, bus.arready);
            end
        end
        @(negedge clk);
        bus.arvalid = 1'b0; bus.bready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (bus.bvalid !== 1'b0) begin n_fail++; $display("FAIL bp_bdone bvalid=%b expected 0", bus.bvalid); end
        do_read(32'h1C);
    endtask

    task automatic test_alias_lone();
        do_write(32'h84, $urandom, 4'hF);
        do_read(32'h04);
        do_write(32'hFFFF_FF93, $urandom, 4'hF);
        do_read(32'h10);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.awaddr = 32'h20; bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF;
            bus.awvalid = (i < 4); bus.wvalid = (i >= 4);
            #1;
            n_checks++;
            if (bus.awready !== 1'b0 || bus.wready !== 1'b0 || ram_ce !== 1'b0) begin
                n_fail++;
                $display("FAIL lone_chan cyc=%0d awready=%b wready=%b ram_ce=%b expected 0 0 0", i, bus.awready, bus.wready, ram_ce);
            end
        end
        idle_inputs();
        do_read(32'h20);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.awaddr = 32'h14; bus.wdata = $urandom; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        ref_write(32'h14, bus.wdata, 4'hF);
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        #1;
        n_checks++;
        if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_b_pre bvalid=%b expected 1", bus.bvalid); end
        reset = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (bus.bvalid !== 1'b0 || dut.state_q !== IDLE) begin
            n_fail++; $display("FAIL rstmid_b bvalid=%b state=%0d expected 0 IDLE", bus.bvalid, dut.state_q);
        end
        reset = 1'b0; bus.bready = 1'b1; ref_last_write = 1'b1;
        @(negedge clk);
        bus.araddr = 32'h04; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.arvalid = 1'b0; reset = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (bus.rvalid !== 1'b0 || dut.state_q !== IDLE || bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_r rvalid=%b state=%0d rdata=%h expected 0 IDLE 0", bus.rvalid, dut.state_q, bus.rdata);
        end
        reset = 1'b0; ref_last_write = 1'b1;
        do_read(32'h14);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)));
            else                          do_read(a);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_strobes();
        test_reset();
        test_contention();
        test_backpressure();
        test_alias_lone();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
